alu_pipe_system: RTL

- Parametrised successor of the single-cycle ALU datapath.
- Integrates a general-purpose register file of NUM_REGS x DATA_WIDTH with a flag-producing ALU, behind a 2-stage execute/writeback pipeline and valid/ready handshakes on both the op and result sides.
- Operand forwarding removes read-after-write stalls, so back-to-back dependent micro-ops issue every cycle.
- Sits between the control sequencer (issues micro-ops) and memory/address logic (consumes results).

---
 rtl/alu_pipe_system_if.sv | 36 +++
 rtl/alu_pipe_system.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_system_if.sv
// Micro-op issue and result return channel between the control sequencer
// (master) and alu_pipe_system (slave).
interface alu_pipe_system_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8
);
  localparam int AW = $clog2(NUM_REGS);

  logic                  Op_Valid;
  logic                  Op_Ready;
  logic [3:0]            Op_FunSel;
  logic [AW-1:0]         Op_SrcA;
  logic [AW-1:0]         Op_SrcB;
  logic [AW-1:0]         Op_Dst;
  logic [DATA_WIDTH-1:0] Op_Imm;
  logic                  Op_ImmSel;
  logic                  Op_WE;
  logic                  Op_WF;

  logic                  Res_Valid;
  logic                  Res_Ready;
  logic [DATA_WIDTH-1:0] Res_Data;
  logic [AW-1:0]         Res_Dst;

  modport master (
    output Op_Valid, Op_FunSel, Op_SrcA, Op_SrcB, Op_Dst, Op_Imm,
           Op_ImmSel, Op_WE, Op_WF, Res_Ready,
    input  Op_Ready, Res_Valid, Res_Data, Res_Dst
  );

  modport slave (
    input  Op_Valid, Op_FunSel, Op_SrcA, Op_SrcB, Op_Dst, Op_Imm,
           Op_ImmSel, Op_WE, Op_WF, Res_Ready,
    output Op_Ready, Res_Valid, Res_Data, Res_Dst
  );
endinterface

// File: rtl/alu_pipe_system.sv
// Register file + flag-producing ALU behind a 2-stage execute/writeback
// pipeline with operand forwarding and valid/ready on op and result sides.
module alu_pipe_system #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 8,
  localparam int AW        = $clog2(NUM_REGS)
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  alu_pipe_system_if.slave      bus,
  output logic [3:0]            Flags,
  input  logic [AW-1:0]         Dbg_Sel,
  output logic [DATA_WIDTH-1:0] Dbg_Data
);
  localparam int MSB = DATA_WIDTH - 1;

  localparam logic [3:0] F_PASSA = 4'b0000;
  localparam logic [3:0] F_PASSB = 4'b0001;
  localparam logic [3:0] F_NOTA  = 4'b0010;
  localparam logic [3:0] F_NOTB  = 4'b0011;
  localparam logic [3:0] F_ADD   = 4'b0100;
  localparam logic [3:0] F_ADC   = 4'b0101;
  localparam logic [3:0] F_SUB   = 4'b0110;
  localparam logic [3:0] F_AND   = 4'b0111;
  localparam logic [3:0] F_OR    = 4'b1000;
  localparam logic [3:0] F_XOR   = 4'b1001;
  localparam logic [3:0] F_SHL   = 4'b1010;
  localparam logic [3:0] F_SHR   = 4'b1011;
  localparam logic [3:0] F_SAR   = 4'b1100;
  localparam logic [3:0] F_ROL   = 4'b1101;
  localparam logic [3:0] F_ROR   = 4'b1110;
  localparam logic [3:0] F_NAND  = 4'b1111;

  logic [DATA_WIDTH-1:0] rf [NUM_REGS];

  // X stage
  logic                  x_valid;
  logic [3:0]            x_fun;
  logic [DATA_WIDTH-1:0] x_a;
  logic [DATA_WIDTH-1:0] x_b;
  logic [AW-1:0]         x_dst;
  logic                  x_we;
  logic                  x_wf;

  // W stage
  logic                  w_valid;
  logic [DATA_WIDTH-1:0] w_data;
  logic [AW-1:0]         w_dst;
  logic                  w_we;

  logic                  stall;
  logic                  op_ready;
  logic                  accept;
  logic                  retire;

  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_c;
  logic                  alu_o;
  logic [DATA_WIDTH-1:0] add_b;
  logic                  add_cin;
  logic [DATA_WIDTH:0]   sum;
  logic                  c_flag;
  logic                  o_flag;

  logic                  fa_x, fa_w, fb_x, fb_w;
  logic [DATA_WIDTH-1:0] opnd_a;
  logic [DATA_WIDTH-1:0] reg_b;
  logic [DATA_WIDTH-1:0] opnd_b;

  assign stall    = w_valid & ~bus.Res_Ready;
  assign op_ready = ~(x_valid & stall);
  assign accept   = bus.Op_Valid & op_ready;
  assign retire   = w_valid & bus.Res_Ready;

  assign bus.Op_Ready  = op_ready;
  assign bus.Res_Valid = w_valid;
  assign bus.Res_Data  = w_data;
  assign bus.Res_Dst   = w_dst;

  assign Dbg_Data = rf[Dbg_Sel];

  assign c_flag = Flags[2];
  assign o_flag = Flags[0];

  // Forwarding: the live X result beats W, which beats the register file.
  // W data equals what the RF receives on a simultaneous retire, so a
  // same-edge write is never read stale.
  assign fa_x = x_valid & x_we & (x_dst == bus.Op_SrcA);
  assign fa_w = w_valid & w_we & (w_dst == bus.Op_SrcA);
  assign fb_x = x_valid & x_we & (x_dst == bus.Op_SrcB);
  assign fb_w = w_valid & w_we & (w_dst == bus.Op_SrcB);

  assign opnd_a = fa_x ? alu_res : (fa_w ? w_data : rf[bus.Op_SrcA]);
  assign reg_b  = fb_x ? alu_res : (fb_w ? w_data : rf[bus.Op_SrcB]);
  assign opnd_b = bus.Op_ImmSel ? bus.Op_Imm : reg_b;

  // Shared adder: subtract is A + ~B + 1, so carry-out means "no borrow".
  always_comb begin
    add_b   = x_b;
    add_cin = 1'b0;
    if (x_fun == F_SUB) begin
      add_b   = ~x_b;
      add_cin = 1'b1;
    end else if (x_fun == F_ADC) begin
      add_cin = c_flag;
    end
    sum = {1'b0, x_a} + {1'b0, add_b} + {{DATA_WIDTH{1'b0}}, add_cin};
  end

  always_comb begin
    alu_res = '0;
    alu_c   = c_flag;
    alu_o   = o_flag;
    case (x_fun)
      F_PASSB: alu_res = x_b;
      F_NOTA:  alu_res = ~x_a;
      F_NOTB:  alu_res = ~x_b;
      F_ADD, F_ADC, F_SUB: begin
        alu_res = sum[MSB:0];
        alu_c   = sum[DATA_WIDTH];
        alu_o   = (x_a[MSB] == add_b[MSB]) && (sum[MSB] != x_a[MSB]);
      end
      F_AND:   alu_res = x_a & x_b;
      F_OR:    alu_res = x_a | x_b;
      F_XOR:   alu_res = x_a ^ x_b;
      F_SHL: begin
        alu_res = {x_a[MSB-1:0], 1'b0};
        alu_c   = x_a[MSB];
      end
      F_SHR: begin
        alu_res = {1'b0, x_a[MSB:1]};
        alu_c   = x_a[0];
      end
      F_SAR: begin
        alu_res = {x_a[MSB], x_a[MSB:1]};
        alu_c   = x_a[0];
      end
      F_ROL: begin
        alu_res = {x_a[MSB-1:0], c_flag};
        alu_c   = x_a[MSB];
      end
      F_ROR: begin
        alu_res = {c_flag, x_a[MSB:1]};
        alu_c   = x_a[0];
      end
      F_NAND:  alu_res = ~(x_a & x_b);
      default: alu_res = x_a;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      x_valid <= 1'b0;
      x_fun   <= '0;
      x_a     <= '0;
      x_b     <= '0;
      x_dst   <= '0;
      x_we    <= 1'b0;
      x_wf    <= 1'b0;
    end else if (op_ready) begin
      x_valid <= bus.Op_Valid;
      if (accept) begin
        x_fun <= bus.Op_FunSel;
        x_a   <= opnd_a;
        x_b   <= opnd_b;
        x_dst <= bus.Op_Dst;
        x_we  <= bus.Op_WE;
        x_wf  <= bus.Op_WF;
      end
    end
  end

  // Flags move with X->W so a following carry-user sees this op's carry.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      w_valid <= 1'b0;
      w_data  <= '0;
      w_dst   <= '0;
      w_we    <= 1'b0;
      Flags   <= '0;
    end else if (!stall) begin
      w_valid <= x_valid;
      if (x_valid) begin
        w_data <= alu_res;
        w_dst  <= x_dst;
        w_we   <= x_we;
        if (x_wf)
          Flags <= {(alu_res == '0), alu_c, alu_res[MSB], alu_o};
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)
      rf <= '{default: '0};
    else if (retire && w_we)
      rf[w_dst] <= w_data;
  end

endmodule
